// File: rtl/spectrum_frame_writer.sv
// FFT output -> approximate magnitude -> 11-bit bins, double-buffered into the spectrum RAM.
// Define SPEC_LOG_EN to emit log-encoded {exponent, mantissa} bins instead of linear.
module spectrum_frame_writer #(
  parameter int N_BINS  = 4096,
  parameter int SHIFT   = 4,
  parameter int MIN_GAP = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        freeze,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic [15:0] s_re,
  input  logic [15:0] s_im,
  output logic        wea,
  output logic [12:0] addra,
  output logic [10:0] dina,
  output logic        disp_bank,
  output logic        frame_done,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CAPTURE, DRAIN, SWAP, DISCARD} state_t;

  localparam logic [12:0] NB   = 13'(N_BINS);
  localparam logic [12:0] LAST = 13'(N_BINS - 1);
  // DRAIN + SWAP must fit inside the upstream idle gap
  localparam int DW = $clog2(MIN_GAP);
  localparam logic [DW-1:0] DLAST = DW'(3);

  state_t state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic wr_bank_q, wr_bank_d;
  logic disp_bank_q, disp_bank_d;
  logic disc_q, disc_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [12:0] cur;
  logic cap, take, gap_hit;

  logic [15:0] a1_q, a1_d, b1_q, b1_d;
  logic        v1_q, v1_d;
  logic [12:0] ad1_q, ad1_d;
  logic [15:0] mx2_q, mx2_d, mn2_q, mn2_d;
  logic        v2_q, v2_d;
  logic [12:0] ad2_q, ad2_d;
  logic [16:0] mag3_q, mag3_d;
  logic        v3_q, v3_d;
  logic [12:0] ad3_q, ad3_d;
  logic        wea_q, wea_d;
  logic [12:0] addra_q, addra_d;
  logic [10:0] dina_q, dina_d;
`ifdef SPEC_LOG_EN
  logic [4:0] lg_e;
  logic [5:0] lg_m;
`else
  logic [16:0] lin_v;
`endif

  function automatic logic [15:0] abs16(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7fff;
    else if (x[15]) return ~x + 16'd1;
    else return x;
  endfunction

  assign cur = (state_q == IDLE) ? '0 : cnt_q;
  assign cap = s_valid &&
    ((state_q == IDLE && enable && !freeze) || state_q == CAPTURE);
  assign take = cap && (cur < NB);
  assign gap_hit = s_valid && (state_q == DRAIN || state_q == SWAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      wr_bank_q   <= 1'b0;
      disp_bank_q <= 1'b1;
      disc_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      a1_q <= '0; b1_q <= '0; v1_q <= 1'b0; ad1_q <= '0;
      mx2_q <= '0; mn2_q <= '0; v2_q <= 1'b0; ad2_q <= '0;
      mag3_q <= '0; v3_q <= 1'b0; ad3_q <= '0;
      wea_q <= 1'b0; addra_q <= '0; dina_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      wr_bank_q   <= wr_bank_d;
      disp_bank_q <= disp_bank_d;
      disc_q      <= disc_d;
      done_q      <= done_d;
      err_q       <= err_d;
      a1_q <= a1_d; b1_q <= b1_d; v1_q <= v1_d; ad1_q <= ad1_d;
      mx2_q <= mx2_d; mn2_q <= mn2_d; v2_q <= v2_d; ad2_q <= ad2_d;
      mag3_q <= mag3_d; v3_q <= v3_d; ad3_q <= ad3_d;
      wea_q <= wea_d; addra_q <= addra_d; dina_q <= dina_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    disc_d      = disc_q;
    wr_bank_d   = wr_bank_q;
    disp_bank_d = disp_bank_q;
    unique case (state_q)
      IDLE, CAPTURE: begin
        drain_d = '0;
        disc_d  = 1'b0;
        if (cap) begin
          cnt_d = take ? cur + 13'd1 : cur;
          if (s_last) state_d = (cur == LAST) ? DRAIN : IDLE;
          else state_d = CAPTURE;
        end else if (state_q == IDLE && s_valid && enable && !s_last) begin
          state_d = DISCARD;
        end
      end
      DRAIN: begin
        // an early frame is dropped, but the finished one still swaps in
        if (gap_hit) disc_d = !s_last;
        if (drain_q == DLAST) state_d = SWAP;
        else drain_d = drain_q + 1'b1;
      end
      SWAP: begin
        disp_bank_d = wr_bank_q;
        wr_bank_d   = ~wr_bank_q;
        disc_d      = 1'b0;
        state_d = (gap_hit ? !s_last : disc_q) ? DISCARD : IDLE;
      end
      DISCARD: if (s_valid && s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) cnt_d = '0;
  end

  always_comb begin
    done_d = (state_q == SWAP);
    err_d  = (cap && s_last && cur != LAST) || (gap_hit && !disc_q);
    busy   = (state_q != IDLE);
  end

  always_comb begin
    a1_d  = abs16(s_re);
    b1_d  = abs16(s_im);
    v1_d  = take;
    ad1_d = {wr_bank_q, cur[11:0]};
    mx2_d = (a1_q > b1_q) ? a1_q : b1_q;
    mn2_d = (a1_q > b1_q) ? b1_q : a1_q;
    v2_d  = v1_q;
    ad2_d = ad1_q;
    mag3_d = {1'b0, mx2_q} + {3'b0, mn2_q[15:2]} + {4'b0, mn2_q[15:3]};
    v3_d   = v2_q;
    ad3_d  = ad2_q;
    wea_d   = v3_q;
    addra_d = ad3_q;
`ifdef SPEC_LOG_EN
    lg_e = '0;
    for (int i = 0; i < 17; i++) if (mag3_q[i]) lg_e = 5'(i);
    lg_m = 6'({mag3_q, 6'b0} >> lg_e);
    dina_d = {lg_e, lg_m};
`else
    lin_v  = mag3_q >> SHIFT;
    dina_d = (lin_v > 17'd2047) ? 11'h7ff : lin_v[10:0];
`endif
  end

  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign disp_bank  = disp_bank_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spectrum_frame_writer.sv
// Bench for spectrum_frame_writer: frame-level reference model and write scoreboard.
module tb_spectrum_frame_writer;

  localparam int NB      = 4096;
  localparam int SHIFT   = 4;
  localparam int MIN_GAP = 6;

  logic clk = 1'b0;
  logic rst, enable, freeze, s_valid, s_last;
  logic [15:0] s_re, s_im;
  logic wea, disp_bank, frame_done, frame_err, busy;
  logic [12:0] addra;
  logic [10:0] dina;

  spectrum_frame_writer dut (
    .clk(clk), .rst(rst), .enable(enable), .freeze(freeze),
    .s_valid(s_valid), .s_last(s_last), .s_re(s_re), .s_im(s_im),
    .wea(wea), .addra(addra), .dina(dina), .disp_bank(disp_bank),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] obs_a[$];
  logic [10:0] obs_d[$];
  int obs_c[$];
  int n_done = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (wea) begin
      obs_a.push_back(addra);
      obs_d.push_back(dina);
      obs_c.push_back(cyc);
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
  end

  logic [12:0] exp_a[$];
  logic [10:0] exp_d[$];
  int exp_done = 0;
  int exp_err = 0;
  bit m_wr = 1'b0;
  bit m_disp = 1'b1;
  bit last_good = 1'b0;
  int last_gap = 100;
  int ck = 0;
  int fs_cyc = 0;
  int total = 0;
  int bad = 0;

  function automatic logic [10:0] ref_dina(input logic [15:0] re, input logic [15:0] im);
    int ar, ai, mx, mn, mag;
`ifdef SPEC_LOG_EN
    int e, m;
`else
    int v;
`endif
    ar = int'($signed(re));
    ai = int'($signed(im));
    if (ar < 0) ar = -ar;
    if (ai < 0) ai = -ai;
    if (ar > 32767) ar = 32767;
    if (ai > 32767) ai = 32767;
    mx = (ar > ai) ? ar : ai;
    mn = (ar > ai) ? ai : ar;
    mag = mx + mn / 4 + mn / 8;
`ifdef SPEC_LOG_EN
    if (mag == 0) return 11'd0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    m = (e >= 6) ? ((mag >> (e - 6)) & 63) : ((mag << (6 - e)) & 63);
    return 11'(e * 64 + m);
`else
    v = mag >> SHIFT;
    if (v > 2047) v = 2047;
    return 11'(v);
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input int mode, output logic [15:0] re, output logic [15:0] im);
    if (mode == 0) begin
      re = 16'd300;
      im = 16'(-400);
    end else if (mode == 2) begin
      re = 16'h8000;
      im = 16'h8000;
    end else begin
      re = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
      im = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
    end
  endtask

  // One frame of len samples, s_last on the final one, then gap idle cycles.
  task automatic send_frame(input int len, input bit frz, input bit en,
                            input int mode, input int gap);
    bit tight, cap;
    logic [15:0] re, im;
    tight = last_good && (last_gap < MIN_GAP);
    cap = en && !frz && !tight;
    if (tight) exp_err++;
    for (int i = 0; i < len; i++) begin
      step();
      pick(mode, re, im);
      s_valid = 1'b1;
      s_last = (i == len - 1);
      s_re = re;
      s_im = im;
      if (i == 0) begin
        enable = en;
        freeze = frz;
        fs_cyc = cyc;
      end
      if (cap && i < NB) begin
        exp_a.push_back({m_wr, 12'(i)});
        exp_d.push_back(ref_dina(re, im));
      end
    end
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (gap - 1) step();
    if (cap) begin
      if (len == NB) begin
        exp_done++;
        m_disp = m_wr;
        m_wr = ~m_wr;
      end else begin
        exp_err++;
      end
    end
    last_good = cap && (len == NB);
    last_gap = gap;
  endtask

  task automatic check(input string tag);
    int nbad, n;
    nbad = 0;
    chk({tag, "/nwr"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int j = ck; j < n; j++)
      if (obs_a[j] !== exp_a[j] || obs_d[j] !== exp_d[j]) nbad++;
    chk({tag, "/wrbad"}, nbad, 0);
    ck = n;
    chk({tag, "/done"}, n_done, exp_done);
    chk({tag, "/err"}, n_err, exp_err);
    chk({tag, "/disp"}, int'(disp_bank), int'(m_disp));
    chk({tag, "/busy"}, int'(busy), 0);
  endtask

  initial begin
    int rc, base;
    logic [15:0] re, im;
    rst = 1'b1;
    enable = 1'b0;
    freeze = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_re = '0;
    s_im = '0;
    repeat (3) step();
    chk("rst/wea", int'(wea), 0);
    chk("rst/addra", int'(addra), 0);
    chk("rst/dina", int'(dina), 0);
    chk("rst/done", int'(frame_done), 0);
    chk("rst/err", int'(frame_err), 0);
    chk("rst/busy", int'(busy), 0);
    chk("rst/disp", int'(disp_bank), 1);
    rst = 1'b0;
    step();

    send_frame(NB, 1'b0, 1'b1, 0, 12);
    check("full1");
    chk("full1/latency", obs_c[0], fs_cyc + 4);
`ifdef SPEC_LOG_EN
    chk("full1/dina", int'(obs_d[0]), 576);
`else
    chk("full1/dina", int'(obs_d[0]), 32);
`endif
    chk("full1/lastaddr", int'(obs_a[NB - 1]), NB - 1);

    send_frame(NB, 1'b0, 1'b1, 1, 12);
    check("full2");
    chk("full2/firstaddr", int'(obs_a[NB]), 4096);

    send_frame(101, 1'b0, 1'b1, 1, 12);
    check("short");
    send_frame(NB, 1'b0, 1'b1, 1, 12);
    check("same_bank");
    send_frame(200, 1'b1, 1'b1, 1, 12);
    check("freeze");
    send_frame(50, 1'b0, 1'b0, 1, 12);
    check("disabled");
    send_frame(64, 1'b0, 1'b1, 2, 12);
    check("sat");
`ifndef SPEC_LOG_EN
    chk("sat/val", int'(obs_d[obs_d.size() - 1]), 2047);
`endif
    send_frame(NB, 1'b0, 1'b1, 1, 2);
    send_frame(300, 1'b0, 1'b1, 1, 12);
    check("gap");
    send_frame(NB + 4, 1'b0, 1'b1, 1, 12);
    check("overlong");

    // Reset lands 2000-i cycles after sample i; only writes already out survive.
    base = exp_a.size();
    for (int i = 0; i < 2000; i++) begin
      step();
      pick(1, re, im);
      s_valid = 1'b1;
      s_last = 1'b0;
      s_re = re;
      s_im = im;
      enable = 1'b1;
      freeze = 1'b0;
      if (2000 - i >= 4) begin
        exp_a.push_back({m_wr, 12'(i)});
        exp_d.push_back(ref_dina(re, im));
      end
      if (i == 1000) chk("mid/busy", int'(busy), 1);
    end
    step();
    rst = 1'b1;
    s_valid = 1'b0;
    rc = cyc;
    step();
    rst = 1'b0;
    m_wr = 1'b0;
    m_disp = 1'b1;
    last_good = 1'b0;
    repeat (10) step();
    check("rst_mid");
    chk("rst_mid/nwr", exp_a.size() - base, 1997);
    chk("rst_mid/late", int'(obs_c[obs_c.size() - 1] <= rc), 1);

    send_frame(NB, 1'b0, 1'b1, 1, 12);
    check("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
